// File: rtl/mul_pipe_if.sv
// Handshake bundle for mul_pipe: op request side (in_*) and result side (out_*).
interface mul_pipe_if #(
  parameter int XLEN = 32,
  parameter int TAGW = 5
);
  logic            in_ready;
  logic            in_valid;
  logic [1:0]      in_sign;
  logic            in_hi;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [TAGW-1:0] in_tag;

  logic              out_ready;
  logic              out_valid;
  logic [2*XLEN-1:0] out_prod;
  logic [XLEN-1:0]   out_res;
  logic [TAGW-1:0]   out_tag;

  modport master (
    input  in_ready,
    output in_valid, in_sign, in_hi, in_a, in_b, in_tag,
    output out_ready,
    input  out_valid, out_prod, out_res, out_tag
  );

  modport slave (
    output in_ready,
    input  in_valid, in_sign, in_hi, in_a, in_b, in_tag,
    input  out_ready,
    output out_valid, out_prod, out_res, out_tag
  );
endinterface

// File: rtl/mul_pipe.sv
// Fully pipelined XLEN x XLEN multiplier (MUL/MULH/MULHSU/MULHU) with tag,
// per-slot backpressure and pipeline-wide flush. Latency = STAGES cycles.
module mul_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int TAGW   = 5
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     flush,
  output logic     busy,
  mul_pipe_if.slave bus
);

  logic [STAGES-1:0]                 vld_pipe;
  logic [STAGES-1:0]                 rdy;
  logic [STAGES-1:0][2*XLEN-1:0]     prod_q;
  logic [STAGES-1:0]                 hi_q;
  logic [STAGES-1:0][TAGW-1:0]       tag_q;

  // Extending each operand to the full product width makes the truncated
  // 2*XLEN product identical to the (XLEN+1)-bit signed multiply.
  logic                     sa, sb;
  logic signed [2*XLEN-1:0] ea, eb;
  logic [2*XLEN-1:0]        prod_c;

  assign sa     = bus.in_sign[1] & bus.in_a[XLEN-1];
  assign sb     = bus.in_sign[0] & bus.in_b[XLEN-1];
  assign ea     = {{XLEN{sa}}, bus.in_a};
  assign eb     = {{XLEN{sb}}, bus.in_b};
  assign prod_c = ea * eb;

  // A slot may load when it is empty or everything downstream can move.
  always_comb begin : ready_chain
    logic acc;
    acc = bus.out_ready;
    rdy = '0;
    for (int i = STAGES-1; i >= 0; i--) begin
      acc    = acc | ~vld_pipe[i];
      rdy[i] = acc;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else begin
      if (rdy[0]) vld_pipe[0] <= bus.in_valid;
      for (int i = 1; i < STAGES; i++)
        if (rdy[i]) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Datapath is not reset; contents only matter under a set valid bit.
  always_ff @(posedge clock) begin
    if (rdy[0]) begin
      prod_q[0] <= prod_c;
      hi_q[0]   <= bus.in_hi;
      tag_q[0]  <= bus.in_tag;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (rdy[i]) begin
        prod_q[i] <= prod_q[i-1];
        hi_q[i]   <= hi_q[i-1];
        tag_q[i]  <= tag_q[i-1];
      end
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = vld_pipe[STAGES-1];
  assign bus.out_prod  = prod_q[STAGES-1];
  assign bus.out_res   = hi_q[STAGES-1] ? prod_q[STAGES-1][2*XLEN-1:XLEN]
                                        : prod_q[STAGES-1][XLEN-1:0];
  assign bus.out_tag   = tag_q[STAGES-1];
  assign busy          = |vld_pipe;

endmodule

// File: tb/tb_mul_pipe.sv
// Directed bench for mul_pipe: STAGES=3/XLEN=32 main instance plus a
// STAGES=1/XLEN=64 instance for the single-entry configuration.
module tb_mul_pipe;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic flush1 = 1'b0;
  logic busy, busy1;
  int   total = 0;
  int   bad = 0;

  mul_pipe_if #(.XLEN(32), .TAGW(5)) bus ();
  mul_pipe_if #(.XLEN(64), .TAGW(5)) bus1 ();

  mul_pipe #(.XLEN(32), .STAGES(3), .TAGW(5)) dut (
    .clock(clock), .reset(reset), .flush(flush), .busy(busy), .bus(bus.slave)
  );
  mul_pipe #(.XLEN(64), .STAGES(1), .TAGW(5)) dut1 (
    .clock(clock), .reset(reset), .flush(flush1), .busy(busy1), .bus(bus1.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] p;
    logic [31:0] r;
    logic [4:0]  t;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic h,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    bus.in_valid = v;
    bus.in_sign  = s;
    bus.in_hi    = h;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = t;
  endtask

  // Reference: widen each operand to 64 bits by its signedness, multiply mod 2^64.
  function automatic logic [63:0] model(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = s[1] ? longint'($signed(a)) : longint'({32'b0, a});
    sb = s[0] ? longint'($signed(b)) : longint'({32'b0, b});
    return 64'(sa * sb);
  endfunction

  task automatic run_op(input string nm, input logic [1:0] s, input logic h,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] t,
                        input logic [63:0] ep, input logic [31:0] er);
    bus.out_ready = 1'b1;
    drive(1'b1, s, h, a, b, t);
    #1 chk({nm, "_in_ready"}, bus.in_ready, 1);
    tick;
    bus.in_valid = 1'b0;
    tick;
    chk({nm, "_early"}, bus.out_valid, 0);
    tick;
    chk({nm, "_valid"}, bus.out_valid, 1);
    chk({nm, "_prod"}, bus.out_prod, ep);
    chk({nm, "_res"}, bus.out_res, er);
    chk({nm, "_tag"}, bus.out_tag, t);
  endtask

  initial begin
    int n, sent, got, cyc;
    logic [1:0]  rs;
    logic        rh;
    logic [31:0] ra, rb;
    logic [63:0] rp;
    exp_t        e;

    drive(1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 5'd0);
    bus.out_ready  = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_sign   = 2'b00;
    bus1.in_hi     = 1'b0;
    bus1.in_a      = '0;
    bus1.in_b      = '0;
    bus1.in_tag    = '0;
    bus1.out_ready = 1'b0;

    tick; tick;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst1_out_valid", bus1.out_valid, 0);
    chk("rst1_busy", busy1, 0);
    reset = 1'b1;

    // Async reset mid-stream with a full, stalled pipe
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'b00, 1'b0, 32'(k + 2), 32'd3, 5'(k));
      tick;
    end
    chk("fill_busy", busy, 1);
    chk("fill_out_valid", bus.out_valid, 1);
    chk("fill_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    #1 reset = 1'b1;
    tick;
    chk("arst_no_stale", bus.out_valid, 0);
    chk("arst_busy_after", busy, 0);

    // Arithmetic modes
    run_op("mul_ss",   2'b11, 1'b0, 32'hFFFFFFFF, 32'd2,        5'd1, 64'hFFFFFFFF_FFFFFFFE, 32'hFFFFFFFE);
    run_op("mulhu",    2'b00, 1'b1, 32'hFFFFFFFF, 32'd2,        5'd2, 64'h00000001_FFFFFFFE, 32'h00000001);
    run_op("mulhsu",   2'b10, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 64'hFFFFFFFF_00000001, 32'hFFFFFFFF);
    run_op("mul_min",  2'b11, 1'b0, 32'h80000000, 32'h80000000, 5'd4, 64'h40000000_00000000, 32'h00000000);
    run_op("mulh_m1",  2'b11, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 64'h00000000_00000001, 32'h00000000);
    tick;

    // Throughput: 8 back-to-back ops, results on 8 consecutive cycles
    bus.out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k < 8) drive(1'b1, 2'b00, 1'b0, 32'(k + 1), 32'(k + 3), 5'(k));
      else bus.in_valid = 1'b0;
      #1;
      if (k < 8) chk("tp_in_ready", bus.in_ready, 1);
      chk("tp_out_valid", bus.out_valid, (k >= 3 && k <= 10) ? 1 : 0);
      if (k >= 3 && k <= 10) begin
        chk("tp_tag", bus.out_tag, 128'(k - 3));
        chk("tp_prod", bus.out_prod, 128'((k - 2) * k));
      end
      tick;
    end

    // Backpressure: exactly 3 accepts, then release and drain in order
    bus.out_ready = 1'b0;
    n = 0;
    repeat (5) begin
      drive(1'b1, 2'b00, 1'b0, 32'(n + 5), 32'd7, 5'(10 + n));
      #1;
      if (bus.in_ready) n++;
      tick;
    end
    chk("bp_accepts", n, 3);
    chk("bp_in_ready_full", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", bus.in_ready, 1);
    chk("bp_drain0_valid", bus.out_valid, 1);
    chk("bp_drain0_tag", bus.out_tag, 10);
    chk("bp_drain0_prod", bus.out_prod, 35);
    tick;
    bus.in_valid = 1'b0;
    for (int j = 1; j < 4; j++) begin
      chk("bp_drain_valid", bus.out_valid, 1);
      chk("bp_drain_tag", bus.out_tag, 128'(10 + j));
      chk("bp_drain_prod", bus.out_prod, 128'((j + 5) * 7));
      tick;
    end
    chk("bp_empty_valid", bus.out_valid, 0);
    chk("bp_empty_busy", busy, 0);

    // Random out_ready / in_valid against the reference model
    sent = 0; got = 0; cyc = 0;
    while (got < 1000 && cyc < 20000) begin
      rs = 2'($urandom);
      rh = 1'($urandom);
      ra = $urandom;
      rb = $urandom;
      if (sent < 1000 && $urandom_range(0, 3) != 0) drive(1'b1, rs, rh, ra, rb, 5'(sent));
      else bus.in_valid = 1'b0;
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) chk("rand_extra_out", 0, 1);
        else begin
          e = q.pop_front();
          chk("rand_prod", bus.out_prod, e.p);
          chk("rand_res", bus.out_res, e.r);
          chk("rand_tag", bus.out_tag, e.t);
          got++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        rp  = model(rs, ra, rb);
        e.p = rp;
        e.r = rh ? rp[63:32] : rp[31:0];
        e.t = 5'(sent);
        q.push_back(e);
        sent++;
      end
      tick;
      cyc++;
    end
    chk("rand_count", got, 1000);

    // Flush with 3 in flight plus a same-cycle accept
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'b00, 1'b0, 32'd9, 32'(k + 1), 5'(20 + k));
      tick;
    end
    drive(1'b1, 2'b00, 1'b0, 32'd9, 32'd9, 5'd23);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    #1;
    chk("fl_in_ready", bus.in_ready, 1);
    chk("fl_busy_before", busy, 1);
    tick;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_out_valid", bus.out_valid, 0);
    chk("fl_busy", busy, 0);
    repeat (4) begin
      tick;
      chk("fl_no_ghost", bus.out_valid, 0);
    end
    run_op("post_flush", 2'b00, 1'b0, 32'd1000, 32'd1000, 5'd24, 64'd1000000, 32'd1000000);

    // Single-stage, 64-bit instance
    bus1.out_ready = 1'b1;
    bus1.in_valid  = 1'b1;
    bus1.in_sign   = 2'b00;
    bus1.in_hi     = 1'b1;
    bus1.in_a      = 64'hFFFFFFFF_FFFFFFFF;
    bus1.in_b      = 64'hFFFFFFFF_FFFFFFFF;
    bus1.in_tag    = 5'd17;
    #1 chk("s1_in_ready", bus1.in_ready, 1);
    tick;
    bus1.in_valid = 1'b0;
    chk("s1_valid", bus1.out_valid, 1);
    chk("s1_res", bus1.out_res, 128'hFFFFFFFF_FFFFFFFE);
    chk("s1_prod", bus1.out_prod, 128'hFFFFFFFF_FFFFFFFE_00000000_00000001);
    chk("s1_tag", bus1.out_tag, 17);
    tick;
    chk("s1_drained", bus1.out_valid, 0);
    chk("s1_busy", busy1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
